air_hockey_puck: RTL
====================

Name: air_hockey_puck

Overview:
- Puck engine for the air hockey screen; the consumer of the paddle positions.
- Reads userPaddleX/Y and audioPaddleX/Y every move tick, advances the puck and bounces it off walls and paddles.
- Detects goals, keeps the score and sequences serve / play / goal / game-over.
- Provides the puck pixel-appear signal and colour to the OLED compositor, in the same x/y pixel scheme as the paddles.

Parameters:
- SPEED, 1, pixels moved per tick on each axis (1..3).
- SERVE_TICKS, 30, ticks the puck sits at centre before it moves.
- GOAL_TICKS, 30, ticks the puck stays hidden after a goal.
- WIN_SCORE, 7, score that ends the game (1..15).
- PUCK_COL, 16'hFFFF, puck colour (RGB565).

Ports:
- clkPuck  in  1  block clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle move-enable pulse (frame rate)
- sw15  in  1  game enable
- x, y  in  7 each  current OLED pixel coordinate
- userPaddleX, userPaddleY  in  7 each  left paddle centre
- audioPaddleX, audioPaddleY  in  7 each  right paddle centre
- puckX, puckY  out  7 each  puck centre
- puckAppear  out  1  pixel (x,y) lies inside the puck
- puck_col  out  16  puck colour
- userScore, audioScore  out  4 each  scores
- goalFlag  out  1  high while in GOAL
- gameOver  out  1  high while in OVER

Behaviour:
- Geometry
  - Screen is 96x64. Puck is 3x3 about its centre.
  - Legal centre range: X 1..94, Y 1..62. Centre position is (48,32).
  - Paddles are 3 wide x 20 tall. Paddle rows are pY-10..pY+9; paddle columns are pX-1..pX+1.
  - All comparisons use 8-bit signed internal arithmetic, so no 7-bit underflow is possible.
- Reset (synchronous, highest priority):
  - state=IDLE, puckX=48, puckY=32.
  - dx=+1, dy=-1, counter=0, scores=0.
  - goalFlag=0, gameOver=0.
- States
  - IDLE
    - Puck held at centre, counter=0.
    - sw15=1 → SERVE.
  - SERVE
    - Counter increments on each tick; puck held at centre.
    - When counter reaches SERVE_TICKS-1 on a tick → PLAY, counter cleared.
  - PLAY
    - On a tick with sw15=1, apply the movement rules below.
    - sw15=0 freezes the puck: state, position and direction are held.
  - GOAL
    - goalFlag=1, puckAppear forced 0. Counter counts ticks.
    - At GOAL_TICKS-1: if either score equals WIN_SCORE → OVER; else puck recentred, dy inverted → SERVE.
  - OVER
    - gameOver=1, puck held where it is.
    - sw15=0 → IDLE with scores cleared.
- Movement per PLAY tick (X and Y axes evaluated independently in the same cycle)
  - Y axis, top wall: dy=-1 and puckY<1+SPEED → dy=+1, puckY+=SPEED.
  - Y axis, bottom wall: dy=+1 and puckY>62-SPEED → dy=-1, puckY-=SPEED.
  - Y axis, otherwise: puckY+=dy*SPEED.
  - X axis, user paddle hit, all of:
    - dx=-1,
    - puckX>=userPaddleX+2,
    - puckX<=userPaddleX+2+SPEED,
    - puckY in userPaddleY-11..userPaddleY+10.
    - Response: dx=+1, puckX+=SPEED.
  - X axis, audio paddle hit: mirror of the user rule.
    - dx=+1, puckX<=audioPaddleX-2, puckX>=audioPaddleX-2-SPEED, same Y window on audioPaddleY.
    - Response: dx=-1, puckX-=SPEED.
  - X axis, left goal: no paddle hit, dx=-1, puckX<1+SPEED → audioScore+=1 (saturating at 15), serve direction dx=-1, → GOAL.
  - X axis, right goal: symmetric → userScore+=1, serve direction dx=+1, → GOAL.
  - X axis, otherwise: puckX+=dx*SPEED.
  - A paddle hit takes priority over a goal. A wall bounce and a paddle hit in the same tick both apply. In a goal tick the position is not updated.
- Output timing
  - puckX, puckY, scores and flags are registered; they update one clkPuck cycle after the tick.
  - puckAppear is combinational: |x-puckX|<=1 and |y-puckY|<=1, and state is not GOAL.
  - puck_col = PUCK_COL, constant.
- tick outside PLAY/SERVE/GOAL is ignored. A tick coincident with reset is ignored.

Test Plan:
- Reset then sw15=1 → puck at (48,32), puckAppear true at pixels (47..49, 31..33); puck stays put for 30 ticks, moves to (49,31) on tick 31.
- Start at (60,2), dx=+1, dy=-1, SPEED=1 → one tick gives (61,1), the next gives dy=+1 and (62,2).
- User paddle at (3,32), puck at (6,40), dx=-1 → tick gives dx=+1 and puckX=7. Same case with puckY=50 → puck misses, reaches X=0 region, audioScore=1, goalFlag high for 30 ticks, then puck recentred with dy inverted.
- Audio paddle at (93,20), puck at (90,9), dx=+1 → bounce to puckX=89 (edge row 9 = 20-11 hits).
- userScore=6 with WIN_SCORE=7 plus a right-goal event → userScore=7, gameOver=1 after GOAL; sw15=0 → IDLE with scores 0.
- sw15=0 mid-PLAY for 10 ticks → position unchanged; reset asserted mid-GOAL → IDLE, centre, scores 0 on the next cycle.

Source files
------------

// File: rtl/air_hockey_puck.sv
// Puck engine: serve/play/goal/over sequencing, wall and paddle bounces, scoring, pixel hit test.
// Latency: position, scores and flags register one clkPuck after the tick; puckAppear is combinational.
// Backpressure: none; tick is a free-running move enable and sw15 gates play.
module air_hockey_puck #(
    parameter int          SPEED       = 1,
    parameter int          SERVE_TICKS = 30,
    parameter int          GOAL_TICKS  = 30,
    parameter int          WIN_SCORE   = 7,
    parameter logic [15:0] PUCK_COL    = 16'hFFFF
) (
    input  logic        clkPuck,
    input  logic        reset,
    input  logic        tick,
    input  logic        sw15,
    input  logic [6:0]  x,
    input  logic [6:0]  y,
    input  logic [6:0]  userPaddleX,
    input  logic [6:0]  userPaddleY,
    input  logic [6:0]  audioPaddleX,
    input  logic [6:0]  audioPaddleY,
    output logic [6:0]  puckX,
    output logic [6:0]  puckY,
    output logic        puckAppear,
    output logic [15:0] puck_col,
    output logic [3:0]  userScore,
    output logic [3:0]  audioScore,
    output logic        goalFlag,
    output logic        gameOver
);
    typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_GOAL, S_OVER} state_t;

    localparam logic [6:0]        CX         = 7'd48;
    localparam logic [6:0]        CY         = 7'd32;
    localparam logic signed [7:0] SP         = 8'(SPEED);
    localparam logic signed [7:0] TOP_LIM    = 8'sd1 + SP;
    localparam logic signed [7:0] BOT_LIM    = 8'sd62 - SP;
    localparam logic signed [7:0] RGT_LIM    = 8'sd94 - SP;
    localparam logic [15:0]       SERVE_LAST = 16'(SERVE_TICKS - 1);
    localparam logic [15:0]       GOAL_LAST  = 16'(GOAL_TICKS - 1);
    localparam logic [3:0]        WIN        = 4'(WIN_SCORE);

    state_t      r_state;
    logic [6:0]  r_puckX, r_puckY;
    logic        r_dx_pos, r_dy_pos;
    logic [15:0] r_cnt;
    logic [3:0]  r_userScore, r_audioScore;
    logic        r_goalFlag, r_gameOver;

    logic signed [7:0] w_px, w_py, w_ux, w_uy, w_ax, w_ay, w_nx, w_ny, w_ddx, w_ddy;
    logic w_top, w_bot, w_uhit, w_ahit, w_lgoal, w_rgoal, w_ndx, w_ndy;

    assign w_px = $signed({1'b0, r_puckX});
    assign w_py = $signed({1'b0, r_puckY});
    assign w_ux = $signed({1'b0, userPaddleX});
    assign w_uy = $signed({1'b0, userPaddleY});
    assign w_ax = $signed({1'b0, audioPaddleX});
    assign w_ay = $signed({1'b0, audioPaddleY});

    // Both axes are resolved from the pre-move position, so the paddle Y window uses the current puckY.
    always_comb begin
        w_top = !r_dy_pos && (w_py < TOP_LIM);
        w_bot = r_dy_pos && (w_py > BOT_LIM);
        w_ndy = r_dy_pos;
        w_ny  = r_dy_pos ? w_py + SP : w_py - SP;
        if (w_top) begin
            w_ndy = 1'b1;
            w_ny  = w_py + SP;
        end else if (w_bot) begin
            w_ndy = 1'b0;
            w_ny  = w_py - SP;
        end

        w_uhit = !r_dx_pos && (w_px >= w_ux + 8'sd2) && (w_px <= w_ux + 8'sd2 + SP)
                 && (w_py >= w_uy - 8'sd11) && (w_py <= w_uy + 8'sd10);
        w_ahit = r_dx_pos && (w_px <= w_ax - 8'sd2) && (w_px >= w_ax - 8'sd2 - SP)
                 && (w_py >= w_ay - 8'sd11) && (w_py <= w_ay + 8'sd10);
        w_lgoal = !r_dx_pos && !w_uhit && (w_px < TOP_LIM);
        w_rgoal = r_dx_pos && !w_ahit && (w_px > RGT_LIM);
        w_ndx = r_dx_pos;
        w_nx  = r_dx_pos ? w_px + SP : w_px - SP;
        if (w_uhit) begin
            w_ndx = 1'b1;
            w_nx  = w_px + SP;
        end else if (w_ahit) begin
            w_ndx = 1'b0;
            w_nx  = w_px - SP;
        end
    end

    always_ff @(posedge clkPuck) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_puckX      <= CX;
            r_puckY      <= CY;
            r_dx_pos     <= 1'b1;
            r_dy_pos     <= 1'b0;
            r_cnt        <= '0;
            r_userScore  <= '0;
            r_audioScore <= '0;
            r_goalFlag   <= 1'b0;
            r_gameOver   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_puckX <= CX;
                    r_puckY <= CY;
                    r_cnt   <= '0;
                    if (sw15) r_state <= S_SERVE;
                end
                S_SERVE: begin
                    if (tick) begin
                        if (r_cnt == SERVE_LAST) begin
                            r_state <= S_PLAY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick && sw15) begin
                        // A goal tick freezes position and dy; only score and serve direction change.
                        if (w_lgoal) begin
                            r_audioScore <= (r_audioScore == 4'd15) ? 4'd15 : r_audioScore + 4'd1;
                            r_dx_pos     <= 1'b0;
                            r_state      <= S_GOAL;
                            r_goalFlag   <= 1'b1;
                            r_cnt        <= '0;
                        end else if (w_rgoal) begin
                            r_userScore <= (r_userScore == 4'd15) ? 4'd15 : r_userScore + 4'd1;
                            r_dx_pos    <= 1'b1;
                            r_state     <= S_GOAL;
                            r_goalFlag  <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_puckX  <= w_nx[6:0];
                            r_puckY  <= w_ny[6:0];
                            r_dx_pos <= w_ndx;
                            r_dy_pos <= w_ndy;
                        end
                    end
                end
                S_GOAL: begin
                    if (tick) begin
                        if (r_cnt == GOAL_LAST) begin
                            r_cnt      <= '0;
                            r_goalFlag <= 1'b0;
                            if (r_userScore == WIN || r_audioScore == WIN) begin
                                r_state    <= S_OVER;
                                r_gameOver <= 1'b1;
                            end else begin
                                r_state  <= S_SERVE;
                                r_puckX  <= CX;
                                r_puckY  <= CY;
                                r_dy_pos <= !r_dy_pos;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (!sw15) begin
                        r_state      <= S_IDLE;
                        r_gameOver   <= 1'b0;
                        r_userScore  <= '0;
                        r_audioScore <= '0;
                        r_puckX      <= CX;
                        r_puckY      <= CY;
                        r_cnt        <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ddx = $signed({1'b0, x}) - w_px;
    assign w_ddy = $signed({1'b0, y}) - w_py;

    assign puckAppear = (r_state != S_GOAL) && (w_ddx >= -8'sd1) && (w_ddx <= 8'sd1)
                        && (w_ddy >= -8'sd1) && (w_ddy <= 8'sd1);
    assign puckX      = r_puckX;
    assign puckY      = r_puckY;
    assign puck_col   = PUCK_COL;
    assign userScore  = r_userScore;
    assign audioScore = r_audioScore;
    assign goalFlag   = r_goalFlag;
    assign gameOver   = r_gameOver;
endmodule
